// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - issue stage: register-file reads, writeback bypass, hazard scoreboard, output register
module operand_fetch #(
    parameter int CTRL_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_rs1_addr,
    input  logic              in_rs1_used,
    input  logic [4:0]        in_rs2_addr,
    input  logic              in_rs2_used,
    input  logic [4:0]        in_rd_addr,
    input  logic              in_rd_wr,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              rf_rd_ch0_en,
    output logic [4:0]        rf_rd_ch0_addr,
    input  logic [31:0]       rf_rd_ch0_data,
    output logic              rf_rd_ch1_en,
    output logic [4:0]        rf_rd_ch1_addr,
    input  logic [31:0]       rf_rd_ch1_data,
    input  logic              wb_en,
    input  logic [4:0]        wb_addr,
    input  logic [31:0]       wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_rs1_data,
    output logic [31:0]       out_rs2_data,
    output logic [4:0]        out_rd_addr,
    output logic              out_rd_wr,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [31:0]       sb_busy
);

    logic              out_valid_q, out_valid_d;
    logic [31:0]       out_rs1_q, out_rs1_d;
    logic [31:0]       out_rs2_q, out_rs2_d;
    logic [4:0]        out_rd_q, out_rd_d;
    logic              out_rd_wr_q, out_rd_wr_d;
    logic [CTRL_W-1:0] out_ctrl_q, out_ctrl_d;
    logic [31:0]       busy_q, busy_d;

    logic        wb_hit1, wb_hit2, wb_hit_rd;
    logic        raw1, raw2, waw;
    logic        slot_free, issue, kill_rd;
    logic [31:0] op1, op2;

    assign rf_rd_ch0_en   = in_valid & in_rs1_used;
    assign rf_rd_ch0_addr = in_rs1_addr;
    assign rf_rd_ch1_en   = in_valid & in_rs2_used;
    assign rf_rd_ch1_addr = in_rs2_addr;

    // Register file only commits writeback at the edge, so same-cycle data must be forwarded.
    assign wb_hit1   = wb_en & (wb_addr == in_rs1_addr) & (in_rs1_addr != 5'd0);
    assign wb_hit2   = wb_en & (wb_addr == in_rs2_addr) & (in_rs2_addr != 5'd0);
    assign wb_hit_rd = wb_en & (wb_addr == in_rd_addr);

    always_comb begin
        op1 = 32'd0;
        op2 = 32'd0;
        if (in_rs1_used) begin
            op1 = wb_hit1 ? wb_data : rf_rd_ch0_data;
        end
        if (in_rs2_used) begin
            op2 = wb_hit2 ? wb_data : rf_rd_ch1_data;
        end
    end

    assign raw1 = in_rs1_used & (in_rs1_addr != 5'd0) & busy_q[in_rs1_addr] & ~wb_hit1;
    assign raw2 = in_rs2_used & (in_rs2_addr != 5'd0) & busy_q[in_rs2_addr] & ~wb_hit2;
    assign waw  = in_rd_wr & (in_rd_addr != 5'd0) & busy_q[in_rd_addr] & ~wb_hit_rd;

    assign slot_free = ~out_valid_q | out_ready;
    assign in_ready  = ~flush & ~raw1 & ~raw2 & ~waw & slot_free;
    assign issue     = in_valid & in_ready;

    // A flushed instruction never reaches writeback, so its reservation is released here.
    assign kill_rd = flush & out_valid_q & out_rd_wr_q & (out_rd_q != 5'd0);

    always_comb begin
        out_valid_d = out_valid_q;
        out_rs1_d   = out_rs1_q;
        out_rs2_d   = out_rs2_q;
        out_rd_d    = out_rd_q;
        out_rd_wr_d = out_rd_wr_q;
        out_ctrl_d  = out_ctrl_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (issue) begin
            out_valid_d = 1'b1;
            out_rs1_d   = op1;
            out_rs2_d   = op2;
            out_rd_d    = in_rd_addr;
            out_rd_wr_d = in_rd_wr;
            out_ctrl_d  = in_ctrl;
        end else if (out_valid_q & out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Ordering makes a same-cycle set override the writeback clear.
    always_comb begin
        busy_d = busy_q;
        if (wb_en) begin
            busy_d[wb_addr] = 1'b0;
        end
        if (kill_rd) begin
            busy_d[out_rd_q] = 1'b0;
        end
        if (issue & in_rd_wr) begin
            busy_d[in_rd_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_rs1_q   <= 32'd0;
            out_rs2_q   <= 32'd0;
            out_rd_q    <= 5'd0;
            out_rd_wr_q <= 1'b0;
            out_ctrl_q  <= '0;
            busy_q      <= 32'd0;
        end else begin
            out_valid_q <= out_valid_d;
            out_rs1_q   <= out_rs1_d;
            out_rs2_q   <= out_rs2_d;
            out_rd_q    <= out_rd_d;
            out_rd_wr_q <= out_rd_wr_d;
            out_ctrl_q  <= out_ctrl_d;
            busy_q      <= busy_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_rs1_data = out_rs1_q;
    assign out_rs2_data = out_rs2_q;
    assign out_rd_addr  = out_rd_q;
    assign out_rd_wr    = out_rd_wr_q;
    assign out_ctrl     = out_ctrl_q;
    assign sb_busy      = busy_q;

endmodule

// File: tb/tb_operand_fetch.sv
// tb/tb_operand_fetch.sv - directed self-checking bench for operand_fetch
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        reset_n, flush, in_valid, in_ready;
    logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
    logic        in_rs1_used, in_rs2_used, in_rd_wr;
    logic [31:0] in_ctrl;
    logic        rf_rd_ch0_en, rf_rd_ch1_en;
    logic [4:0]  rf_rd_ch0_addr, rf_rd_ch1_addr;
    logic [31:0] rf_rd_ch0_data, rf_rd_ch1_data;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        out_valid, out_ready, out_rd_wr;
    logic [31:0] out_rs1_data, out_rs2_data, out_ctrl, sb_busy;
    logic [4:0]  out_rd_addr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    operand_fetch #(.CTRL_W(32)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1_addr(in_rs1_addr), .in_rs1_used(in_rs1_used),
        .in_rs2_addr(in_rs2_addr), .in_rs2_used(in_rs2_used),
        .in_rd_addr(in_rd_addr), .in_rd_wr(in_rd_wr), .in_ctrl(in_ctrl),
        .rf_rd_ch0_en(rf_rd_ch0_en), .rf_rd_ch0_addr(rf_rd_ch0_addr), .rf_rd_ch0_data(rf_rd_ch0_data),
        .rf_rd_ch1_en(rf_rd_ch1_en), .rf_rd_ch1_addr(rf_rd_ch1_addr), .rf_rd_ch1_data(rf_rd_ch1_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
        .out_rd_addr(out_rd_addr), .out_rd_wr(out_rd_wr), .out_ctrl(out_ctrl),
        .sb_busy(sb_busy)
    );

    task automatic set_in(input logic v, input logic [4:0] r1, input logic u1, input logic [4:0] r2,
                          input logic u2, input logic [4:0] rd, input logic wr, input logic [31:0] ctrl);
        in_valid = v; in_rs1_addr = r1; in_rs1_used = u1; in_rs2_addr = r2; in_rs2_used = u2;
        in_rd_addr = rd; in_rd_wr = wr; in_ctrl = ctrl;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
        wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
        rf_rd_ch0_data = 32'd0; rf_rd_ch1_data = 32'd0;
        set_in(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid act %0b exp 0", out_valid); end
        checks++; if (sb_busy !== 32'd0) begin errors++; $display("FAIL reset_sb_busy act %h exp 0", sb_busy); end
        checks++; if (out_rs1_data !== 32'd0 || out_ctrl !== 32'd0 || out_rd_wr !== 1'b0) begin
            errors++; $display("FAIL reset_payload act rs1=%h ctrl=%h wr=%0b exp zeros", out_rs1_data, out_ctrl, out_rd_wr); end
        @(negedge clk); reset_n = 1'b1; #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready act %0b exp 1", in_ready); end
        checks++; if (rf_rd_ch0_en !== 1'b0) begin errors++; $display("FAIL reset_ch0_en act %0b exp 0", rf_rd_ch0_en); end
    endtask

    task automatic test_basic();
        @(negedge clk);
        set_in(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd4, 1'b0, 32'hA5A5_0001);
        rf_rd_ch0_data = 32'h11; rf_rd_ch1_data = 32'h22; out_ready = 1'b1;
        #1;
        checks++; if (rf_rd_ch0_en !== 1'b1 || rf_rd_ch0_addr !== 5'd1 || rf_rd_ch1_en !== 1'b1 || rf_rd_ch1_addr !== 5'd2) begin
            errors++; $display("FAIL basic_rf_ports act en0=%0b a0=%0d en1=%0b a1=%0d exp 1/1/1/2", rf_rd_ch0_en, rf_rd_ch0_addr, rf_rd_ch1_en, rf_rd_ch1_addr); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready act %0b exp 1", in_ready); end
        step();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid act %0b exp 1", out_valid); end
        checks++; if (out_rs1_data !== 32'h11 || out_rs2_data !== 32'h22) begin
            errors++; $display("FAIL basic_operands act %h/%h exp 11/22", out_rs1_data, out_rs2_data); end
        checks++; if (out_ctrl !== 32'hA5A5_0001 || out_rd_addr !== 5'd4 || out_rd_wr !== 1'b0) begin
            errors++; $display("FAIL basic_payload act ctrl=%h rd=%0d wr=%0b exp a5a50001/4/0", out_ctrl, out_rd_addr, out_rd_wr); end
        checks++; if (sb_busy !== 32'd0) begin errors++; $display("FAIL basic_sb_busy act %h exp 0", sb_busy); end
        @(negedge clk);
        set_in(1'b1, 5'd1, 1'b1, 5'd2, 1'b0, 5'd0, 1'b0, 32'h2);
        step();
        checks++; if (out_rs2_data !== 32'd0 || out_rs1_data !== 32'h11) begin
            errors++; $display("FAIL unused_src act %h/%h exp 11/0", out_rs1_data, out_rs2_data); end
        @(negedge clk); in_valid = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drain act %0b exp 0", out_valid); end
    endtask

    task automatic test_raw();
        @(negedge clk);
        set_in(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 32'hA);
        step();
        checks++; if (sb_busy !== 32'h0000_0020) begin errors++; $display("FAIL raw_busy_set act %h exp 00000020", sb_busy); end
        @(negedge clk);
        set_in(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 32'hB);
        rf_rd_ch0_data = 32'h0000_0555;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL raw_stall cyc %0d act %0b exp 0", i, in_ready); end
            @(negedge clk);
        end
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEAD_BEEF;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL raw_release act %0b exp 1", in_ready); end
        step();
        checks++; if (out_valid !== 1'b1 || out_rs1_data !== 32'hDEAD_BEEF || out_ctrl !== 32'hB) begin
            errors++; $display("FAIL raw_bypass act v=%0b rs1=%h ctrl=%h exp 1/deadbeef/b", out_valid, out_rs1_data, out_ctrl); end
        checks++; if (sb_busy !== 32'd0) begin errors++; $display("FAIL raw_busy_clear act %h exp 0", sb_busy); end
        @(negedge clk); wb_en = 1'b0; in_valid = 1'b0;
    endtask

    task automatic test_zero_reg();
        @(negedge clk);
        set_in(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 32'hC0);
        rf_rd_ch0_data = 32'd0;
        wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'h1234_5678;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL zero_no_stall act %0b exp 1", in_ready); end
        step();
        checks++; if (out_rs1_data !== 32'd0) begin errors++; $display("FAIL zero_operand act %h exp 0", out_rs1_data); end
        checks++; if (sb_busy !== 32'd0) begin errors++; $display("FAIL zero_busy act %h exp 0", sb_busy); end
        @(negedge clk); wb_en = 1'b0; in_valid = 1'b0;
        step();
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        set_in(1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 32'hC);
        rf_rd_ch0_data = 32'h77; out_ready = 1'b0;
        step();
        @(negedge clk);
        set_in(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 32'hD);
        rf_rd_ch0_data = 32'h88;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc %0d act %0b exp 0", i, in_ready); end
            step();
            checks++; if (out_valid !== 1'b1 || out_rs1_data !== 32'h77 || out_ctrl !== 32'hC) begin
                errors++; $display("FAIL bp_hold cyc %0d act v=%0b rs1=%h ctrl=%h exp 1/77/c", i, out_valid, out_rs1_data, out_ctrl); end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release act %0b exp 1", in_ready); end
        step();
        checks++; if (out_valid !== 1'b1 || out_rs1_data !== 32'h88 || out_ctrl !== 32'hD) begin
            errors++; $display("FAIL bp_reload act v=%0b rs1=%h ctrl=%h exp 1/88/d", out_valid, out_rs1_data, out_ctrl); end
        @(negedge clk); in_valid = 1'b0;
        step();
    endtask

    task automatic test_flush();
        @(negedge clk);
        set_in(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 32'h3);
        out_ready = 1'b1;
        step();
        @(negedge clk);
        set_in(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 32'h7);
        step();
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        step();
        checks++; if (out_valid !== 1'b1 || out_rd_addr !== 5'd7 || sb_busy !== 32'h0000_0088) begin
            errors++; $display("FAIL flush_setup act v=%0b rd=%0d busy=%h exp 1/7/00000088", out_valid, out_rd_addr, sb_busy); end
        @(negedge clk);
        flush = 1'b1; out_ready = 1'b1;
        set_in(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 32'h9);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready act %0b exp 0", in_ready); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid act %0b exp 0", out_valid); end
        checks++; if (sb_busy !== 32'h0000_0008) begin errors++; $display("FAIL flush_busy act %h exp 00000008", sb_busy); end
        @(negedge clk); flush = 1'b0; in_valid = 1'b0;
    endtask

    task automatic test_waw();
        @(negedge clk);
        set_in(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 32'h33);
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL waw_stall act %0b exp 0", in_ready); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL waw_no_issue act %0b exp 0", out_valid); end
        @(negedge clk);
        wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h3333;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL waw_release act %0b exp 1", in_ready); end
        step();
        checks++; if (out_valid !== 1'b1 || out_rd_addr !== 5'd3 || out_ctrl !== 32'h33) begin
            errors++; $display("FAIL waw_issue act v=%0b rd=%0d ctrl=%h exp 1/3/33", out_valid, out_rd_addr, out_ctrl); end
        checks++; if (sb_busy !== 32'h0000_0008) begin errors++; $display("FAIL waw_set_wins act %h exp 00000008", sb_busy); end
        @(negedge clk); in_valid = 1'b0;
        step();
        @(negedge clk); wb_en = 1'b0;
        checks++; if (sb_busy !== 32'd0) begin errors++; $display("FAIL waw_final_clear act %h exp 0", sb_busy); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_raw();
        test_zero_reg();
        test_backpressure();
        test_flush();
        test_waw();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
Issue stage sitting directly upstream of the register file. It takes decoded instructions, drives both register-file read channels, and bypasses same-cycle writeback data. A 32-entry scoreboard blocks RAW and WAW hazards against in-flight writes. Results are registered into a single output pipeline register with valid/ready handshakes toward the execute stage.

Parameters:
CTRL_W, 32, width of the opaque decoded-control payload carried alongside operands

Ports:
clk  input  1  core clock
reset_n  input  1  asynchronous active-low reset
flush  input  1  kill the instruction in the output register and block issue this cycle
in_valid  input  1  decoded instruction present
in_ready  output  1  instruction accepted this cycle
in_rs1_addr  input  5  source 1 index
in_rs1_used  input  1  source 1 needed
in_rs2_addr  input  5  source 2 index
in_rs2_used  input  1  source 2 needed
in_rd_addr  input  5  destination index
in_rd_wr  input  1  instruction writes rd
in_ctrl  input  CTRL_W  opaque decoded control
rf_rd_ch0_en  output  1  register-file read channel 0 enable
rf_rd_ch0_addr  output  5  read channel 0 address
rf_rd_ch0_data  input  32  read channel 0 data (combinational)
rf_rd_ch1_en  output  1  read channel 1 enable
rf_rd_ch1_addr  output  5  read channel 1 address
rf_rd_ch1_data  input  32  read channel 1 data (combinational)
wb_en  input  1  writeback strobe (same signals that drive the register-file write port)
wb_addr  input  5  writeback index
wb_data  input  32  writeback data
out_valid  output  1  operands valid toward execute
out_ready  input  1  execute accepts
out_rs1_data  output  32  operand 1
out_rs2_data  output  32  operand 2
out_rd_addr  output  5  destination index
out_rd_wr  output  1  destination write flag
out_ctrl  output  CTRL_W  control payload
sb_busy  output  32  scoreboard vector, for debug

Behaviour:
- Read channels: rf_rd_ch0_en = in_valid & in_rs1_used, rf_rd_ch0_addr = in_rs1_addr; channel 1 is the same for rs2. Both are combinational.
- Writeback hit for source s: wb_en & wb_addr==s_addr & s_addr!=0.
- Operand: on a wb hit, take wb_data (the register file updates only at the edge); otherwise take the rf data. An unused source yields 0.
- RAW hazard: s_used & s_addr!=0 & busy[s_addr] & no wb hit.
- WAW hazard: in_rd_wr & in_rd_addr!=0 & busy[in_rd_addr] & !(wb_en & wb_addr==in_rd_addr).
- slot_free = !out_valid | out_ready.
- in_ready = !flush & !raw1 & !raw2 & !waw & slot_free.
- issue = in_valid & in_ready.
- Output register:
  - On issue, load operands, rd, rd_wr and ctrl, and set out_valid=1.
  - Else if out_valid & out_ready, clear out_valid.
  - Else hold all outputs stable.
  - Latency: one cycle from issue to out_valid.
- Scoreboard, per bit i:
  - Bit i clears on wb_en & wb_addr==i.
  - Bit i sets on issue & in_rd_wr & in_rd_addr==i.
  - Set wins over a same-cycle clear.
  - busy[0] is hardwired to 0.
  - A wb_en to a non-busy index is harmless.
- Flush (highest priority):
  - Next cycle out_valid=0.
  - If out_valid & out_rd_wr & out_rd_addr!=0, clear busy[out_rd_addr]; the killed instruction will never write back.
  - out_ready is ignored in a flush cycle; execute must not consume.
  - No issue occurs in the flush cycle.
  - Busy bits of older in-flight instructions are preserved.
- Reset: busy=0, out_valid=0, all out_* payload=0, sb_busy=0. Reset mid-handshake discards the instruction.
- Execute must not assert wb for an index that the output register has not yet handed off. In-order issue guarantees this.

Test Plan:
- Reset, then issue rs1=1 / rs2=2 with RF returning 0x11 / 0x22 and out_ready=1 -> out_valid the next cycle with operands 0x11 / 0x22; sb_busy stays 0 when rd_wr=0.
- Issue rd=5 rd_wr=1, then instruction B with rs1=5 -> in_ready=0 until wb_en addr=5 data=0xDEADBEEF. In that wb cycle B issues with out_rs1_data=0xDEADBEEF, and busy[5] ends at 0.
- rs1=0 rs1_used=1 while wb_en addr=0 -> no stall, operand is the RF value (0); busy[0] stays 0.
- out_ready=0 for 3 cycles with out_valid=1 -> outputs unchanged, in_ready=0; out_ready=1 -> next instruction loads in the same cycle.
- Output register holds rd=7 rd_wr=1 and flush=1 -> next cycle out_valid=0 and busy[7]=0, and no issue occurs in the flush cycle.
- busy[3]=1, new instruction with rd=3 -> stalls (WAW); wb addr=3 in the same cycle -> issues and busy[3] stays 1.
